// File: rtl/ocm_noise_reader.sv
// Purpose: streams a window of 64-bit words from on-chip memory port s2 onto a valid/ready output.
// Latency: start to first out_valid is 3 cycles; sustains 1 word/cycle when FIFO_DEPTH >= 4.
// Backpressure: reads are only issued against free FIFO credits, so no returned word is ever dropped.

module ocm_noise_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push_vld,
  input  logic [W-1:0]     push_dat,
  input  logic             pop_rdy,
  output logic [W-1:0]     head_dat,
  output logic             head_vld,
  output logic [CNT_W-1:0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop;

  assign head_vld = (count != '0);
  assign head_dat = mem[rd_ptr];
  assign pop      = head_vld & pop_rdy;

  // Storage, pointers and occupancy; flush empties the queue without touching storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push_vld, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module ocm_noise_reader #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 64,
  parameter int MEM_WORDS  = 8960,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic                loop_en,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     num_words,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_byteenable,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CRD_W = CNT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] base_q, addr_nx, addr_inc;
  logic [ADDR_W:0]   num_q, cnt_q, cnt_nx;
  logic              loop_q;
  logic              rd_pend;     // a read issued last cycle returns data this cycle
  logic              zero_done;   // empty-window request completes one cycle after start
  logic              issue, drain_done, wrap;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              pop, push, credit;
  logic [CRD_W-1:0]  outst;

  assign mem_write      = 1'b0;
  assign mem_byteenable = '1;

  assign pop  = out_valid & out_ready;
  assign push = rd_pend & ~abort;

  // Every word already held or still on its way through the read pipeline
  // owns a FIFO slot; a pop at this edge frees one for the next issue.
  assign outst  = CRD_W'(fifo_cnt) + CRD_W'(mem_chipselect) + CRD_W'(rd_pend) - CRD_W'(pop);
  assign credit = (outst < CRD_W'(FIFO_DEPTH));

  assign wrap     = (cnt_q == num_q);
  assign addr_inc = (mem_address == ADDR_W'(MEM_WORDS - 1)) ? '0 : mem_address + ADDR_W'(1);

  assign done = ~abort & (zero_done | drain_done);
  assign busy = (state != S_IDLE) & ~drain_done;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next state, issue decision and the address/count of the next read.
  always_comb begin
    state_nx   = state;
    issue      = 1'b0;
    drain_done = 1'b0;
    addr_nx    = mem_address;
    cnt_nx     = cnt_q;
    if (abort) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && num_words != '0) begin
            issue    = 1'b1;
            addr_nx  = base_addr;
            cnt_nx   = (ADDR_W+1)'(1);
            state_nx = (num_words == (ADDR_W+1)'(1) && !loop_en) ? S_DRAIN : S_RUN;
          end
        end
        S_RUN: begin
          if (credit) begin
            issue   = 1'b1;
            // Only a looping window can reach its length while still in RUN.
            addr_nx = wrap ? base_q : addr_inc;
            cnt_nx  = wrap ? (ADDR_W+1)'(1) : cnt_q + (ADDR_W+1)'(1);
            if (!loop_q && cnt_nx == num_q) state_nx = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (fifo_cnt == '0 && !mem_chipselect && !rd_pend) begin
            drain_done = 1'b1;
            state_nx   = S_IDLE;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Read strobe, address, issue count and the parameters latched at start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_chipselect <= 1'b0;
      mem_address    <= '0;
      rd_pend        <= 1'b0;
      zero_done      <= 1'b0;
      cnt_q          <= '0;
      base_q         <= '0;
      num_q          <= '0;
      loop_q         <= 1'b0;
    end else if (abort) begin
      mem_chipselect <= 1'b0;
      rd_pend        <= 1'b0;
      zero_done      <= 1'b0;
    end else begin
      mem_chipselect <= issue;
      rd_pend        <= mem_chipselect;
      zero_done      <= (state == S_IDLE) && start && (num_words == '0);
      if (issue) begin
        mem_address <= addr_nx;
        cnt_q       <= cnt_nx;
      end
      if (state == S_IDLE && start) begin
        base_q <= base_addr;
        num_q  <= num_words;
        loop_q <= loop_en;
      end
    end
  end

  ocm_noise_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (abort),
    .push_vld (push),
    .push_dat (mem_readdata),
    .pop_rdy  (out_ready),
    .head_dat (out_data),
    .head_vld (out_valid),
    .count    (fifo_cnt)
  );
endmodule

// File: tb/tb_ocm_noise_reader.sv
// Bench for ocm_noise_reader: memory model on s2, event logs per cycle, window reference model.
// Cycle k is the interval after edge E(k-1), where E0 samples start.
// Inputs change 1 time unit after a rising edge; outputs are logged on the falling edge.

module tb_ocm_noise_reader;
  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 64;
  localparam int MEM_WORDS  = 8960;
  localparam int FIFO_DEPTH = 4;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic                loop_en = 1'b0;
  logic [ADDR_W-1:0]   base_addr = '0;
  logic [ADDR_W:0]     num_words = '0;
  logic                busy, done, mem_chipselect, mem_write, out_valid;
  logic                out_ready = 1'b0;
  logic [ADDR_W-1:0]   mem_address;
  logic [DATA_W/8-1:0] mem_byteenable;
  logic [DATA_W-1:0]   mem_readdata = '0;
  logic [DATA_W-1:0]   out_data;

  ocm_noise_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .loop_en(loop_en),
    .base_addr(base_addr), .num_words(num_words), .busy(busy), .done(done),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable), .mem_readdata(mem_readdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory contents and the s2 port with its one-cycle read latency.
  logic [63:0] mem_arr [MEM_WORDS];
  always @(posedge clk)
    if (mem_chipselect && !mem_write) mem_readdata <= mem_arr[mem_address];

  int cyc = 0;
  int t0  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event logs filled by the monitor.
  logic [ADDR_W-1:0] addr_q[$];
  logic [63:0]       dat_q[$];
  int                dat_cyc_q[$];
  int                done_cyc_q[$];
  int                busy_at_done = 0;
  bit                busy_seen = 0;
  bit                hold_prev = 0;
  logic [63:0]       hold_dat = '0;
  int                rel = 0;

  // Falling-edge monitor: logs reads, transfers and done; checks held data stays put.
  always @(negedge clk) begin
    rel = cyc - t0 + 1;
    if (reset_n) begin
      if (mem_chipselect) addr_q.push_back(mem_address);
      if (out_valid && out_ready) begin
        dat_q.push_back(out_data);
        dat_cyc_q.push_back(rel);
      end
      if (done) begin
        done_cyc_q.push_back(rel);
        if (busy) busy_at_done++;
      end
      if (busy) busy_seen = 1;
      if (hold_prev && out_valid) check_eq("hold_stable", out_data, hold_dat);
      hold_prev = out_valid && !out_ready;
      hold_dat  = out_data;
    end else begin
      hold_prev = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    addr_q.delete();
    dat_q.delete();
    dat_cyc_q.delete();
    done_cyc_q.delete();
    busy_at_done = 0;
    busy_seen    = 0;
  endtask

  // Returns one time unit after E0, i.e. early in cycle 1.
  task automatic do_start(input int base, input int num, input bit lp);
    @(posedge clk);
    #1;
    clear_logs();
    base_addr = ADDR_W'(base);
    num_words = (ADDR_W+1)'(num);
    loop_en   = lp;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0    = cyc;
  endtask

  // Reference: a window is the words at (base+i) mod MEM_WORDS, in order, once each.
  task automatic expect_window(input string tag, input int base, input int num,
                               input int first_cyc, input bit contiguous);
    int a;
    check_eq({tag, "_nreads"}, addr_q.size(), num);
    check_eq({tag, "_nwords"}, dat_q.size(), num);
    for (int i = 0; i < num && i < addr_q.size() && i < dat_q.size(); i++) begin
      a = (base + i) % MEM_WORDS;
      check_eq({tag, "_addr"}, addr_q[i], a);
      check_eq({tag, "_data"}, dat_q[i], mem_arr[a]);
      if (contiguous) check_eq({tag, "_cycle"}, dat_cyc_q[i], first_cyc + i);
    end
    check_eq({tag, "_ndone"}, done_cyc_q.size(), 1);
    check_eq({tag, "_busy_at_done"}, busy_at_done, 0);
  endtask

  task automatic run_basic(input string tag);
    out_ready = 1'b1;
    do_start(16, 4, 1'b0);
    tick(12);
    expect_window(tag, 16, 4, 3, 1'b1);
    check_eq({tag, "_first_word"}, dat_q.size() > 0 ? dat_q[0] : 64'hx, 64'h1010);
    check_eq({tag, "_done_cycle"}, done_cyc_q.size() > 0 ? done_cyc_q[0] : -1, 7);
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem_arr[i] = {$urandom, $urandom};
    for (int i = 16; i < 20; i++) mem_arr[i] = 64'(i * 32'h0101);

    // Reset values
    tick(2);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_cs", mem_chipselect, 0);
    check_eq("rst_addr", mem_address, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_data", out_data, 0);
    check_eq("rst_write", mem_write, 0);
    check_eq("rst_be", mem_byteenable, 8'hFF);
    reset_n = 1'b1;
    tick(2);

    run_basic("basic");

    // Downstream stalled through cycle 20, then released.
    out_ready = 1'b0;
    do_start(16, 4, 1'b0);
    tick(19);
    check_eq("bp_reads_held", addr_q.size() <= FIFO_DEPTH, 1);
    check_eq("bp_no_xfer", dat_q.size(), 0);
    check_eq("bp_valid_held", out_valid, 1);
    tick(1);
    out_ready = 1'b1;
    tick(10);
    expect_window("bp", 16, 4, 0, 1'b0);

    // Address wrap with random backpressure.
    do_start(8958, 4, 1'b0);
    for (int k = 0; k < 200 && done_cyc_q.size() == 0; k++) begin
      out_ready = ($urandom_range(0, 2) != 0);
      tick(1);
    end
    out_ready = 1'b1;
    tick(3);
    expect_window("wrap", 8958, 4, 0, 1'b0);

    // Empty window.
    do_start(100, 0, 1'b0);
    tick(5);
    check_eq("zero_reads", addr_q.size(), 0);
    check_eq("zero_ndone", done_cyc_q.size(), 1);
    check_eq("zero_done_cycle", done_cyc_q.size() > 0 ? done_cyc_q[0] : -1, 1);
    check_eq("zero_busy", busy_seen, 0);

    // Looping window, ignored restart in cycle 10, abort in cycle 20.
    out_ready = 1'b1;
    do_start(5, 3, 1'b1);
    tick(9);
    base_addr = ADDR_W'(100);
    num_words = (ADDR_W+1)'(2);
    loop_en   = 1'b0;
    start     = 1'b1;
    tick(1);
    start = 1'b0;
    tick(9);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check_eq("abort_valid", out_valid, 0);
    check_eq("abort_busy", busy, 0);
    tick(5);
    check_eq("abort_valid_later", out_valid, 0);
    check_eq("loop_ndone", done_cyc_q.size(), 0);
    check_eq("loop_nwords", dat_q.size(), 18);
    for (int i = 0; i < dat_q.size(); i++) begin
      check_eq("loop_data", dat_q[i], mem_arr[5 + i % 3]);
      check_eq("loop_cycle", dat_cyc_q[i], 3 + i);
    end
    for (int i = 0; i < addr_q.size(); i++) check_eq("loop_addr", addr_q[i], 5 + i % 3);

    // Asynchronous reset with a full FIFO, then a fresh run.
    out_ready = 1'b0;
    do_start(16, 8, 1'b0);
    tick(10);
    check_eq("pre_rst_busy", busy, 1);
    reset_n = 1'b0;
    #2;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_done", done, 0);
    check_eq("arst_cs", mem_chipselect, 0);
    check_eq("arst_addr", mem_address, 0);
    check_eq("arst_valid", out_valid, 0);
    check_eq("arst_data", out_data, 0);
    tick(1);
    reset_n = 1'b1;
    tick(1);
    run_basic("after_rst");

    // Random windows under random backpressure.
    for (int r = 0; r < 6; r++) begin
      int b, n;
      b = $urandom_range(0, MEM_WORDS - 1);
      n = $urandom_range(1, 24);
      do_start(b, n, 1'b0);
      for (int k = 0; k < 400 && done_cyc_q.size() == 0; k++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        tick(1);
      end
      out_ready = 1'b1;
      tick(3);
      expect_window("rand", b, n, 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
